// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between a group of requesters and the round-robin arbiter.
// The requesters drive request/control lines; the arbiter drives the grant side.
interface rr_arbiter_if #(
   parameter int N = 8
);
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     req;
   logic             en;
   logic             mode;
   logic             lock;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] ptr;
   logic             req_up;

   modport master (
      output req, en, mode, lock,
      input  gnt, gnt_valid, gnt_idx, ptr, req_up
   );

   modport slave (
      input  req, en, mode, lock,
      output gnt, gnt_valid, gnt_idx, ptr, req_up
   );
endinterface

// File: rtl/rr_arbiter.sv
// N-way registered arbiter with rotate-past-winner round-robin, fixed-priority mode
// and grant locking bounded to HOLD_MAX consecutive cycles.
module rr_arbiter #(
   parameter int  N        = 8,
   parameter int  HOLD_MAX = 4,
   localparam int IDX_W    = $clog2(N)
) (
   input logic         clock,
   input logic         reset,
   rr_arbiter_if.slave bus
);
   localparam int               HOLD_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
   localparam logic [IDX_W:0]    N_WIDE    = (IDX_W + 1)'(N);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

   logic [N-1:0]      gnt_r, gnt_s;
   logic              gnt_valid_r, gnt_valid_s;
   logic [IDX_W-1:0]  gnt_idx_r, gnt_idx_s;
   logic [IDX_W-1:0]  ptr_r, ptr_s;
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
   logic [IDX_W-1:0]  rr_idx_s, fix_idx_s, win_idx_s;
   logic              rr_found_s, fix_found_s, win_found_s, hold_s;

   assign bus.gnt       = gnt_r;
   assign bus.gnt_valid = gnt_valid_r;
   assign bus.gnt_idx   = gnt_idx_r;
   assign bus.ptr       = ptr_r;
   assign bus.req_up    = |bus.req;

   // Rotating search from ptr; scanning farthest-first lets the nearest requester win.
   always_comb begin
      logic [IDX_W:0]   cand;
      logic [IDX_W-1:0] idx;
      rr_found_s = 1'b0;
      rr_idx_s   = '0;
      cand       = '0;
      idx        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand       = {1'b0, ptr_r} + (IDX_W + 1)'(k);
         cand       = (cand >= N_WIDE) ? (cand - N_WIDE) : cand;
         idx        = cand[IDX_W-1:0];
         rr_found_s = rr_found_s | bus.req[idx];
         rr_idx_s   = bus.req[idx] ? idx : rr_idx_s;
      end
   end

   // Fixed-priority search: lowest requesting index wins.
   always_comb begin
      fix_found_s = 1'b0;
      fix_idx_s   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         fix_found_s = fix_found_s | bus.req[k];
         fix_idx_s   = bus.req[k] ? IDX_W'(k) : fix_idx_s;
      end
   end

   // Next-state selection: disable, then bounded hold, then fresh arbitration.
   always_comb begin
      gnt_s       = gnt_r;
      gnt_valid_s = gnt_valid_r;
      gnt_idx_s   = gnt_idx_r;
      ptr_s       = ptr_r;
      hold_cnt_s  = hold_cnt_r;
      win_idx_s   = bus.mode ? fix_idx_s : rr_idx_s;
      win_found_s = bus.mode ? fix_found_s : rr_found_s;
      hold_s      = gnt_valid_r && bus.req[gnt_idx_r] && bus.lock && (hold_cnt_r < HOLD_LAST);
      if (!bus.en) begin
         gnt_s       = '0;
         gnt_valid_s = 1'b0;
         gnt_idx_s   = '0;
         hold_cnt_s  = '0;
      end else if (hold_s) begin
         hold_cnt_s = hold_cnt_r + HOLD_W'(1);
      end else if (win_found_s) begin
         gnt_s       = N'(1) << win_idx_s;
         gnt_valid_s = 1'b1;
         gnt_idx_s   = win_idx_s;
         hold_cnt_s  = '0;
         if (!bus.mode) begin
            ptr_s = (win_idx_s == IDX_LAST) ? '0 : (win_idx_s + IDX_W'(1));
         end else begin
            ptr_s = ptr_r;
         end
      end else begin
         gnt_s       = '0;
         gnt_valid_s = 1'b0;
         gnt_idx_s   = '0;
         hold_cnt_s  = '0;
      end
   end

   // Grant, pointer and hold counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt_r       <= '0;
         gnt_valid_r <= 1'b0;
         gnt_idx_r   <= '0;
         ptr_r       <= '0;
         hold_cnt_r  <= '0;
      end else begin
         gnt_r       <= gnt_s;
         gnt_valid_r <= gnt_valid_s;
         gnt_idx_r   <= gnt_idx_s;
         ptr_r       <= ptr_s;
         hold_cnt_r  <= hold_cnt_s;
      end
   end
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: an 8-way instance for the main behaviour and a
// 5-way instance for non-power-of-two pointer wrap.
module tb_rr_arbiter;
   logic clock;
   logic reset;
   int   n_assert;
   int   n_fail;

   rr_arbiter_if #(.N(8)) bus8 ();
   rr_arbiter_if #(.N(5)) bus5 ();

   rr_arbiter #(.N(8), .HOLD_MAX(4)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));
   rr_arbiter #(.N(5), .HOLD_MAX(4)) dut5 (.clock(clock), .reset(reset), .bus(bus5.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                       input logic [2:0] ep);
      chk({tag, ".gnt"},       32'(bus8.gnt),       32'(eg));
      chk({tag, ".gnt_valid"}, 32'(bus8.gnt_valid), 32'(eg != 8'h00));
      chk({tag, ".gnt_idx"},   32'(bus8.gnt_idx),   32'(ei));
      chk({tag, ".ptr"},       32'(bus8.ptr),       32'(ep));
   endtask

   task automatic chk5(input string tag, input logic [4:0] eg, input logic [2:0] ei,
                       input logic [2:0] ep);
      chk({tag, ".gnt5"},       32'(bus5.gnt),       32'(eg));
      chk({tag, ".gnt_valid5"}, 32'(bus5.gnt_valid), 32'(eg != 5'h00));
      chk({tag, ".gnt_idx5"},   32'(bus5.gnt_idx),   32'(ei));
      chk({tag, ".ptr5"},       32'(bus5.ptr),       32'(ep));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [2:0] ki;
      n_assert  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      bus8.req  = 8'h00;
      bus8.en   = 1'b1;
      bus8.mode = 1'b0;
      bus8.lock = 1'b0;
      bus5.req  = 5'h00;
      bus5.en   = 1'b1;
      bus5.mode = 1'b0;
      bus5.lock = 1'b0;

      // Reset state
      #1;
      chk8("rst0", 8'h00, 3'd0, 3'd0);
      chk5("rst0", 5'h00, 3'd0, 3'd0);
      chk("rst0.req_up", 32'(bus8.req_up), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Asynchronous reset in the middle of a grant
      bus8.req = 8'h04;
      step();
      chk8("pre_rst", 8'h04, 3'd2, 3'd3);
      #2;
      reset = 1'b0;
      #1;
      chk8("async_rst", 8'h00, 3'd0, 3'd0);
      bus8.req = 8'h00;
      #2;
      reset = 1'b1;
      step();
      chk8("post_rst", 8'h00, 3'd0, 3'd0);

      // Rotation with everyone requesting
      bus8.req = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         step();
         ki = 3'(k % 8);
         chk8("rotate", 8'h01 << ki, ki, ki + 3'd1);
      end

      // Disable clears the grant, pointer kept
      bus8.en = 1'b0;
      step();
      chk8("disable", 8'h00, 3'd0, 3'd2);

      // Lock bound: idx 0 held four cycles, then idx 1
      bus8.en   = 1'b1;
      bus8.req  = 8'h03;
      bus8.lock = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk8("lock_hold", 8'h01, 3'd0, 3'd1);
      end
      step();
      chk8("lock_expire", 8'h02, 3'd1, 3'd2);

      // Sole requester with lock stays granted across hold expiries
      bus8.req = 8'h01;
      for (int k = 0; k < 9; k++) begin
         step();
         chk8("lock_sole", 8'h01, 3'd0, 3'd1);
      end

      // Fixed priority, then back to round-robin from the preserved pointer
      bus8.lock = 1'b0;
      bus8.mode = 1'b1;
      bus8.req  = 8'hA4;
      for (int k = 0; k < 3; k++) begin
         step();
         chk8("fixed", 8'h04, 3'd2, 3'd1);
      end
      bus8.mode = 1'b0;
      step();
      chk8("rr_resume0", 8'h04, 3'd2, 3'd3);
      step();
      chk8("rr_resume1", 8'h20, 3'd5, 3'd6);
      step();
      chk8("rr_resume2", 8'h80, 3'd7, 3'd0);

      // Enable gating and req_up
      bus8.en  = 1'b0;
      bus8.req = 8'h10;
      step();
      chk8("en_off", 8'h00, 3'd0, 3'd0);
      chk("en_off.req_up", 32'(bus8.req_up), 32'd1);
      bus8.en = 1'b1;
      step();
      chk8("en_on", 8'h10, 3'd4, 3'd5);

      // Five-way wrap
      bus5.req = 5'b00100;
      step();
      chk5("n5_set", 5'b00100, 3'd2, 3'd3);
      bus5.req = 5'b00101;
      step();
      chk5("n5_wrap", 5'b00001, 3'd0, 3'd1);
      step();
      chk5("n5_next", 5'b00100, 3'd2, 3'd3);
      bus5.req = 5'b10000;
      step();
      chk5("n5_last", 5'b10000, 3'd4, 3'd0);
      bus5.req = 5'b00000;
      step();
      chk5("n5_idle", 5'b00000, 3'd0, 3'd0);
      chk("n5_idle.req_up", 32'(bus5.req_up), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Parametrised N-way registered round-robin arbiter; next generation of the team's 2/4-way rotating-priority arbiters.
- Adds:
  - arbitrary requester count;
  - true rotate-past-winner fairness, replacing the free-running priority counter;
  - a fixed-priority mode;
  - grant locking with a bounded hold time.
- Sits in front of shared resources (bus, memory port), feeding a registered one-hot grant plus an encoded index.

Parameters:
- N, 8, number of requesters (N >= 2, any value, not restricted to powers of two).
- HOLD_MAX, 4, maximum consecutive cycles one requester may hold a locked grant (>= 1).
- IDX_W, $clog2(N), width of index outputs (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i = requester i.
- en  input  1  arbitration enable; 0 forces no grant.
- mode  input  1  0 = round-robin, 1 = fixed priority (index 0 highest).
- lock  input  1  current holder asks to keep its grant next cycle.
- gnt  output  N  registered one-hot grant (all-zero when none).
- gnt_valid  output  1  registered; 1 when gnt is non-zero.
- gnt_idx  output  IDX_W  registered binary index of the granted requester; 0 when none.
- ptr  output  IDX_W  registered highest-priority index for round-robin search.
- req_up  output  1  combinational OR of req; independent of en, for cascading into a parent arbiter.

Behaviour:
- Reset (reset=0, asynchronous): gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, internal hold_cnt=0. Outputs clear immediately, without waiting for a clock edge. First arbitration happens on the first rising edge after deassertion.
- Latency: req sampled at edge t produces gnt valid after edge t. gnt, gnt_valid and gnt_idx always agree and come from the same flops.
- Each rising edge, the following priority applies; the first rule that matches wins:
  1. en=0: gnt<=0, gnt_valid<=0, gnt_idx<=0, hold_cnt<=0, ptr unchanged.
  2. Hold: a grant is active, req[gnt_idx]=1, lock=1, and hold_cnt < HOLD_MAX-1. Result: grant unchanged, hold_cnt<=hold_cnt+1, ptr unchanged.
  3. Arbitrate:
     - mode=0: winner is the first i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N, including for non-power-of-two N).
     - mode=1: winner is the lowest i with req[i]=1.
     - Any winner: gnt<=onehot(winner), gnt_valid<=1, gnt_idx<=winner, hold_cnt<=0.
     - mode=0 winner only: ptr<=(winner+1) mod N; mode=1 leaves ptr unchanged.
     - No request: gnt<=0, gnt_valid<=0, gnt_idx<=0, hold_cnt<=0, ptr unchanged.
- Hold expiry:
  - After HOLD_MAX consecutive granted cycles the holder enters normal arbitration.
  - In mode=0 the holder has lowest priority and loses to any other requester. If it is the sole requester it re-wins and hold_cnt restarts at 0.
  - In mode=1 it competes by index.
- Holder drops req: released at the next edge, even with lock=1. lock is ignored when no grant is active.
- Mode switch: takes effect at the next arbitration (rule 3). An in-progress lock continues unaffected; ptr is preserved across mode changes.
- Fairness: in mode=0 with lock=0 and all requesting, the grant rotates 0,1,…,N-1,0 every cycle. No requester waits more than (N-1)*HOLD_MAX cycles while requesting continuously with en=1.
- gnt is never multi-hot. A grant is never issued to a non-requesting index.

Test Plan:
- Reset: drive reset=0 mid-grant (gnt=8'h04) -> gnt, gnt_valid, gnt_idx, ptr all 0 before the next edge; after release with req=8'h00 they stay 0.
- Rotation (N=8, mode=0, lock=0): req=8'hFF for 10 cycles -> gnt_idx sequence 0,1,2,3,4,5,6,7,0,1; ptr leads gnt_idx by 1 mod 8.
- Sparse/wrap (N=5): ptr=3 and req=5'b00101 -> grant idx 0, ptr=1; then grant idx 2, ptr=3.
- Lock bound (HOLD_MAX=4): req=8'h03, lock=1 -> idx 0 granted 4 consecutive cycles, then idx 1. Sole requester req=8'h01 with lock=1 -> idx 0 granted continuously.
- Fixed mode: mode=1, req=8'hA4 -> gnt_idx=2 every cycle, ptr unchanged. Switch to mode=0 -> search resumes from the preserved ptr.
- Enable/req_up: en=0 with req=8'h10 -> gnt=0, req_up=1. Set en=1 -> gnt=8'h10 one cycle later.
